// File: rtl/gp_regfile_pkg.sv
// gp_regfile_pkg: shared types and constants for the GP register file.
// State encoding, default geometry and the zero word.
package gp_regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    localparam logic [DEF_XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/gp_regfile_read_port.sv
// gp_regfile_read_port: one registered read port with index-0 mask.
// Optional write-first bypass under GP_REGFILE_BYPASS_EN.
module gp_regfile_read_port
    import gp_regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [XLEN-1:0] rd_word,
`ifdef GP_REGFILE_BYPASS_EN
    input  logic            byp_we,
    input  logic [IDXW-1:0] byp_idx,
    input  logic [XLEN-1:0] byp_data,
`endif
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] rd_nxt;

    // Select next read value: zero while clearing or for x0.
    always_comb begin
        rd_nxt = XLEN'(ZERO_WORD);
        if (run && (rd_idx != '0)) begin
            rd_nxt = rd_word;
        end
`ifdef GP_REGFILE_BYPASS_EN
        if (byp_we && (byp_idx == rd_idx)) begin
            rd_nxt = byp_data;
        end
`endif
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= XLEN'(ZERO_WORD);
        end else begin
            rd_data <= rd_nxt;
        end
    end

endmodule

// File: rtl/gp_regfile_param.sv
// gp_regfile_param: XLEN x NREG register file, NRD read ports, 1 write.
// Self-clearing init; define GP_REGFILE_BYPASS_EN for write-first reads.
module gp_regfile_param
    import gp_regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 2,
    localparam int IDXW = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_req,
    output logic                 ready,
    input  logic [NRD*IDXW-1:0]  rd_idx,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic                 wr_en,
    input  logic [IDXW-1:0]      wr_idx,
    input  logic [XLEN-1:0]      wr_data
);

    state_e          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] mem [NREG];

    logic            run;
    logic            wr_fire;
    logic            mem_we;
    logic [IDXW-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    assign run     = (state_q == ST_RUN);
    assign ready   = run;
    assign wr_fire = run && !clear_req && wr_en && (wr_idx != '0);

    // Next state: INIT sweeps cnt over the array, clear_req restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDXW'(1);
                if (cnt_q == IDXW'(NREG - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array write mux: sweeper owns the port during INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_idx;
        mem_wdata = wr_data;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = XLEN'(ZERO_WORD);
        end else if (wr_fire) begin
            mem_we    = 1'b1;
        end
    end

    // Array storage; contents are cleared by the sweeper, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rp
        gp_regfile_read_port #(
            .XLEN (XLEN),
            .IDXW (IDXW)
        ) u_rp (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .rd_idx   (rd_idx[p*IDXW +: IDXW]),
            .rd_word  (mem[rd_idx[p*IDXW +: IDXW]]),
`ifdef GP_REGFILE_BYPASS_EN
            .byp_we   (wr_fire),
            .byp_idx  (wr_idx),
            .byp_data (wr_data),
`endif
            .rd_data  (rd_data[p*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_gp_regfile_param.sv
// tb_gp_regfile_param: scoreboard bench for gp_regfile_param.
// Reference model predicts reads, ready and the init sweep.
module tb_gp_regfile_param;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int IDXW = 5;

`ifdef GP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                clear_req;
    logic                ready;
    logic [NRD*IDXW-1:0] rd_idx;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [IDXW-1:0]     wr_idx;
    logic [XLEN-1:0]     wr_data;

    gp_regfile_param #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (ready),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] model [NREG];
    bit          m_rdy;
    int          m_cnt;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] port_q(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic cyc(input string tag, input bit we, input int widx,
                       input logic [31:0] wd, input int r0, input int r1,
                       input bit clr);
        int          ri [NRD];
        logic [31:0] e;
        sb_t         s;
        ri[0]     = r0;
        ri[1]     = r1;
        wr_en     = we;
        wr_idx    = IDXW'(widx);
        wr_data   = wd;
        clear_req = clr;
        rd_idx    = {IDXW'(r1), IDXW'(r0)};
        for (int p = 0; p < NRD; p++) begin
            if (!m_rdy || ri[p] == 0) e = '0;
            else if (BYP && !clr && we && widx != 0 && widx == ri[p]) e = wd;
            else e = model[ri[p]];
            s.tag  = tag;
            s.port = p;
            s.exp  = e;
            sb.push_back(s);
        end
        if (!m_rdy) begin
            model[m_cnt] = '0;
            if (m_cnt == NREG - 1) begin
                m_rdy = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (clr) begin
            m_rdy = 1'b0;
            m_cnt = 0;
        end else if (we && widx != 0) begin
            model[widx] = wd;
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            chk($sformatf("%s.p%0d", s.tag, s.port), port_q(s.port), s.exp);
        end
        chk({tag, ".rdy"}, {31'b0, ready}, {31'b0, m_rdy});
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rdy"}, {31'b0, ready}, 32'h0);
        chk({tag, ".p0"}, port_q(0), 32'h0);
        chk({tag, ".p1"}, port_q(1), 32'h0);
        m_rdy = 1'b0;
        m_cnt = 0;
        sb.delete();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_rdy     = 1'b0;
        m_cnt     = 0;
        rst_n     = 1'b0;
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        rd_idx    = '0;
        for (int i = 0; i < NREG; i++) model[i] = 'x;

        repeat (2) @(posedge clk);
        #1;
        do_reset("rst");

        for (int e = 0; e < NREG; e++)
            cyc("init", 1'b0, 0, 0, $urandom_range(31), $urandom_range(31), 1'b0);

        cyc("w5", 1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0);
        cyc("r5", 1'b0, 0, 0, 5, 5, 1'b0);
        cyc("w0", 1'b1, 0, 32'h12345678, 0, 0, 1'b0);
        cyc("r0", 1'b0, 0, 0, 0, 0, 1'b0);

        cyc("w7a", 1'b1, 7, 32'h00000001, 0, 0, 1'b0);
        cyc("w7b", 1'b1, 7, 32'hA5A5A5A5, 7, 7, 1'b0);
        cyc("r7", 1'b0, 0, 0, 7, 5, 1'b0);

        for (int i = 1; i < NREG; i++)
            cyc("fill", 1'b1, i, 32'h10000000 + i * 32'h01010101, 0, 0, 1'b0);
        for (int i = 1; i < NREG; i += 2)
            cyc("rdall", 1'b0, 0, 0, i, (i + 1) % NREG, 1'b0);

        cyc("clr", 1'b1, 3, 32'hFFFF0003, 3, 4, 1'b1);
        for (int e = 0; e < NREG; e++)
            cyc("clrinit", 1'b1, $urandom_range(31), $urandom(),
                $urandom_range(31), $urandom_range(31), 1'b0);
        for (int i = 0; i < NREG; i += 2)
            cyc("rdzero", 1'b0, 0, 0, i, i + 1, 1'b0);

        cyc("w9", 1'b1, 9, 32'h0BADF00D, 0, 0, 1'b0);
        do_reset("rstrun");
        for (int e = 0; e < 10; e++)
            cyc("part", 1'b1, 9, 32'h1, 9, 3, 1'b0);
        do_reset("rstmid");
        for (int e = 0; e < NREG; e++)
            cyc("reinit", 1'b0, 0, 0, 9, $urandom_range(31), 1'b0);
        cyc("r9", 1'b0, 0, 0, 9, 31, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
